// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding and default frame geometry for the capture sequencer
package cam_pkg;
  typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DONE} state_t;
  localparam int H_PIX_DEF = 160;
  localparam int V_LINES_DEF = 120;
endpackage

// File: rtl/cam_edge_det.sv
// cam_edge_det: registers a camera sync level once and flags its rising/falling edges
module cam_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic q_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, q_d} <= 2'b00;
    else {q, q_d} <= {d, q};
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: aligns captures to vsync frames and gates every frame-buffer write
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int AW = 15,
  parameter int H_PIX = H_PIX_DEF,
  parameter int V_LINES = V_LINES_DEF
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          cont_mode,
  input  logic          vsync,
  input  logic          href,
  input  logic          px_vld,
  input  logic [7:0]    px_data,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_data,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err
);
  localparam int PW = $clog2(H_PIX + 1);
  localparam int LW = $clog2(V_LINES + 1);
  state_t state, state_n;
  logic vs, vs_rise, vs_fall, hr, hr_rise, hr_fall;
  logic [PW-1:0] px_cnt, px_eff;
  logic [LW-1:0] line_cnt, lc_n;
  logic [AW-1:0] line_base;
  logic cap, px_in, room, acc, close, line_sat, sync_entry, err_set;
  logic unused_edges;
  cam_edge_det u_vs (.clk(pclk), .rst(rst), .d(vsync), .q(vs), .rise(vs_rise), .fall(vs_fall));
  cam_edge_det u_hr (.clk(pclk), .rst(rst), .d(href), .q(hr), .rise(hr_rise), .fall(hr_fall));
  assign unused_edges = vs ^ hr_rise;
  always_ff @(posedge pclk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ARM;
      ARM:     if (vs_rise) state_n = SYNC;
      SYNC:    if (vs_fall) state_n = CAPTURE;
      CAPTURE: if (vs_rise) state_n = DONE;
      DONE:    state_n = cont_mode ? SYNC : IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    frame_done = state == DONE;
  end
  // A pixel landing on the same cycle as a vsync-truncated line close still counts toward that line
  always_comb begin
    cap = state == CAPTURE && !abort;
    px_in = cap && px_vld && hr;
    room = px_cnt < PW'(H_PIX) && line_cnt < LW'(V_LINES);
    acc = px_in && room;
    px_eff = px_cnt + PW'(acc);
    close = cap && (hr_fall || (vs_rise && hr)) && px_eff != '0;
    line_sat = line_cnt == LW'(V_LINES);
    lc_n = (close && !line_sat) ? line_cnt + LW'(1) : line_cnt;
    sync_entry = state_n == SYNC && state != SYNC;
    err_set = (px_in && !room) || (close && px_eff != PW'(H_PIX)) ||
              (cap && vs_rise && (hr || lc_n != LW'(V_LINES)));
  end
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      buf_we <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      frame_err <= 1'b0;
      px_cnt <= '0;
      line_cnt <= '0;
      line_base <= '0;
    end else begin
      buf_we <= acc;
      if (acc) begin
        buf_data <= px_data;
        buf_addr <= line_base + AW'(px_cnt);
      end
      if (sync_entry) begin
        buf_addr <= '0;
        px_cnt <= '0;
        line_cnt <= '0;
        line_base <= '0;
        frame_err <= 1'b0;
      end else begin
        px_cnt <= close ? '0 : px_eff;
        line_cnt <= lc_n;
        if (close && !line_sat) line_base <= line_base + AW'(H_PIX);
        if (err_set) frame_err <= 1'b1;
      end
    end
endmodule
